// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, loads the start PC from a two-word reset vector,
// and feeds IF/ID every cycle. Optional HALT detection is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
    parameter logic [31:0] VEC_ADDR    = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd1,
    parameter logic [4:0]  HALT_OPCODE = 5'b00001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        iam_bubble,
    output logic [1:0]  fetch_state
);

    typedef enum logic [1:0] {
        S_VEC0 = 2'd0,
        S_VEC1 = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] vec_hi_q, vec_hi_d;
    logic [31:0] pc_inc;
    logic        halt_hit;

    assign pc_inc      = pc_q + PC_STEP;
    assign halt_hit    = HALT_EN && (imem_data[15:11] == HALT_OPCODE);
    assign fetch_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_VEC0;
            pc_q     <= 32'd0;
            vec_hi_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            vec_hi_q <= vec_hi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        vec_hi_d    = vec_hi_q;
        imem_addr   = pc_q;
        instruction = 16'd0;
        pc          = 32'd0;
        next_pc     = 32'd0;
        iam_bubble  = 1'b1;
        case (state_q)
            S_VEC0: begin
                imem_addr = VEC_ADDR;
                vec_hi_d  = imem_data;
                state_d   = S_VEC1;
            end
            S_VEC1: begin
                imem_addr = VEC_ADDR + 32'd1;
                pc_d      = {vec_hi_q, imem_data};
                state_d   = S_RUN;
            end
            S_RUN: begin
                instruction = imem_data;
                pc          = pc_q;
                next_pc     = pc_inc;
                // The word fetched alongside a taken redirect is wrong-path.
                iam_bubble  = redirect;
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (!stall) begin
                    pc_d = pc_inc;
                    if (halt_hit) state_d = S_HALT;
                end
            end
            S_HALT: begin
                pc      = pc_q;
                next_pc = pc_inc;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_VEC0;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: drives reset-vector, stall, redirect, wrap and HALT cases
// and checks every observed cycle against hand-computed expectations via a scoreboard queue.
module tb_fetch_unit;

    localparam int W = 115;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        iam_bubble;
    logic [1:0]  fetch_state;

    logic [15:0] mem [0:255];

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           done     = 1'b0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instruction (instruction),
        .pc          (pc),
        .next_pc     (next_pc),
        .iam_bubble  (iam_bubble),
        .fetch_state (fetch_state)
    );

    // Clock and memory model
    always #5 clk = ~clk;

    assign imem_data = (imem_addr[31:8] == 24'd0) ? mem[imem_addr[7:0]] : 16'hDEAD;

    function automatic logic [W-1:0] mk(input logic [1:0] st, input logic bub,
                                        input logic [15:0] ins, input logic [31:0] p,
                                        input logic [31:0] np, input logic [31:0] addr);
        return {st, bub, ins, p, np, addr};
    endfunction

    function automatic logic [W-1:0] run_exp(input logic [31:0] p, input logic [15:0] ins,
                                             input logic bub);
        return mk(2'd2, bub, ins, p, p + 32'd1, p);
    endfunction

    // Driver tasks
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        string        nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = mk(fetch_state, iam_bubble, instruction, pc, next_pc, imem_addr);
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got st=%0d bub=%0b ins=%h pc=%h npc=%h addr=%h ; exp st=%0d bub=%0b ins=%h pc=%h npc=%h addr=%h",
                         nm, got[114:113], got[112], got[111:96], got[95:64], got[63:32], got[31:0],
                         e[114:113], e[112], e[111:96], e[95:64], e[63:32], e[31:0]);
            end
        end
    end

    initial begin
        #50000;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: bench did not complete within time limit");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0] = 16'h0000;
        mem[1] = 16'h0010;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

        // Reset vector load
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);  expect_out("reset",  mk(2'd0, 1'b1, 16'h0, 32'h0, 32'h0, 32'h0));
        step(0, 0, 0, 0);  expect_out("vec0",   mk(2'd0, 1'b1, 16'h0, 32'h0, 32'h0, 32'h0));
        step(0, 0, 0, 0);  expect_out("vec1",   mk(2'd1, 1'b1, 16'h0, 32'h0, 32'h0, 32'h1));
        step(0, 0, 0, 0);  expect_out("first",  mk(2'd2, 1'b0, 16'hA010, 32'h10, 32'h11, 32'h10));
        step(0, 0, 0, 0);  expect_out("inc11",  mk(2'd2, 1'b0, 16'hA011, 32'h11, 32'h12, 32'h11));

        // Move to 0x20, then stall three cycles
        step(0, 0, 1, 32'h20); expect_out("redir20", run_exp(32'h12, 16'hA012, 1'b1));
        step(0, 1, 0, 0);  expect_out("stall1", run_exp(32'h20, 16'hA020, 1'b0));
        step(0, 1, 0, 0);  expect_out("stall2", run_exp(32'h20, 16'hA020, 1'b0));
        step(0, 1, 0, 0);  expect_out("stall3", run_exp(32'h20, 16'hA020, 1'b0));
        step(0, 0, 0, 0);  expect_out("stall_rel", run_exp(32'h20, 16'hA020, 1'b0));

        // Redirects, including redirect together with stall
        step(0, 0, 1, 32'h30); expect_out("after_stall", run_exp(32'h21, 16'hA021, 1'b1));
        step(0, 0, 1, 32'h80); expect_out("redir80", run_exp(32'h30, 16'hA030, 1'b1));
        step(0, 1, 1, 32'h44); expect_out("tgt80",   run_exp(32'h80, 16'hA080, 1'b1));
        step(0, 0, 0, 0);  expect_out("rs44",   run_exp(32'h44, 16'hA044, 1'b0));
        step(0, 0, 0, 0);  expect_out("inc45",  run_exp(32'h45, 16'hA045, 1'b0));

        // New all-ones vector; reset mid-load must restart from S_VEC0
        mem[0] = 16'hFFFF;
        mem[1] = 16'hFFFF;
        step(1, 0, 0, 0);  expect_out("pre_rst", run_exp(32'h46, 16'hA046, 1'b0));
        step(0, 0, 0, 0);  expect_out("rst_vec0", mk(2'd0, 1'b1, 16'h0, 32'h0, 32'h0, 32'h0));
        step(1, 0, 0, 0);  expect_out("rst_vec1", mk(2'd1, 1'b1, 16'h0, 32'h0, 32'h0, 32'h1));
        step(0, 0, 0, 0);  expect_out("midload", mk(2'd0, 1'b1, 16'h0, 32'h0, 32'h0, 32'h0));
        step(0, 0, 0, 0);  expect_out("reload1", mk(2'd1, 1'b1, 16'h0, 32'h0, 32'h0, 32'h1));
        step(0, 0, 0, 0);  expect_out("wrap_a", mk(2'd2, 1'b0, 16'hDEAD, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF));
        step(0, 0, 0, 0);  expect_out("wrap_b", mk(2'd2, 1'b0, 16'hFFFF, 32'h0, 32'h1, 32'h0));

        // HALT opcode word at 0x10
        mem[16] = 16'h0800;
        step(0, 0, 1, 32'h10); expect_out("redir10", mk(2'd2, 1'b1, 16'hFFFF, 32'h1, 32'h2, 32'h1));
        step(0, 0, 0, 0);  expect_out("halt_word", run_exp(32'h10, 16'h0800, 1'b0));
`ifdef FETCH_HALT_EN
        step(0, 0, 0, 0);  expect_out("halted1", mk(2'd3, 1'b1, 16'h0, 32'h11, 32'h12, 32'h11));
        step(0, 0, 1, 32'h50); expect_out("halted2", mk(2'd3, 1'b1, 16'h0, 32'h11, 32'h12, 32'h11));
        step(0, 0, 0, 0);  expect_out("exit_halt", run_exp(32'h50, 16'hA050, 1'b0));
`else
        step(0, 0, 0, 0);  expect_out("no_halt", run_exp(32'h11, 16'hA011, 1'b0));
        step(0, 0, 0, 0);  expect_out("no_halt2", run_exp(32'h12, 16'hA012, 1'b0));
`endif

        // Drain and report
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
